// File: rtl/tinker_pkg.sv
// Shared constants for the tinker core: architectural register file geometry,
// stack-pointer reset value, pipeline bubble opcode and regfile port-count defaults.
package tinker_pkg;

    localparam int          DATA_W       = 64;
    localparam int          NUM_REGS     = 32;
    localparam int          SP_IDX       = 31;
    localparam logic [63:0] SP_RESET_VAL = 64'd524288;
    localparam logic [4:0]  BUBBLE_OP    = 5'h1f;

    localparam int RF_NUM_RD  = 3;
    localparam int RF_NUM_WR  = 2;
    localparam int RF_NUM_RSV = 1;
    localparam int RF_CNT_W   = 2;
    localparam int RF_BYPASS  = 1;

endpackage

// File: rtl/tinker_sb_cnt.sv
// Pending-write counter for one register: adds issued reservations, subtracts
// retiring writes, clamps at zero on underflow and at the maximum on overflow.
module tinker_sb_cnt #(
    parameter int CNT_W = 2,
    parameter int INC_W = 1,
    parameter int DEC_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             underflow
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    int up;
    int nxt;

    always_comb begin
        up        = int'(cnt) + int'(inc);
        underflow = (up < int'(dec));
        nxt       = underflow ? 0 : up - int'(dec);
        if (nxt > CNT_MAX) nxt = CNT_MAX;
    end

    assign full = (int'(cnt) == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= CNT_W'(nxt);
    end

endmodule

// File: rtl/tinker_regfile_sb.sv
// Multi-port register file with optional same-cycle write bypass and a per-register
// pending-write scoreboard: decode reserves destinations, writeback retires them.
module tinker_regfile_sb
    import tinker_pkg::*;
#(
    parameter int                DATA_W   = tinker_pkg::DATA_W,
    parameter int                NUM_REGS = tinker_pkg::NUM_REGS,
    parameter int                NUM_RD   = RF_NUM_RD,
    parameter int                NUM_WR   = RF_NUM_WR,
    parameter int                NUM_RSV  = RF_NUM_RSV,
    parameter int                CNT_W    = RF_CNT_W,
    parameter int                SP_IDX   = tinker_pkg::SP_IDX,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_VAL),
    parameter int                BYPASS   = RF_BYPASS,
    localparam int               AW       = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*AW-1:0]      wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]  wr_data,
    input  logic [NUM_RSV-1:0]        rsv_en,
    input  logic [NUM_RSV*AW-1:0]     rsv_addr,
    output logic [NUM_RSV-1:0]        rsv_ok,
    output logic [DATA_W-1:0]         sp_val,
    output logic                      sb_err
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int INC_W   = $clog2(NUM_RSV + 1);
    localparam int DEC_W   = $clog2(NUM_WR + 1);

    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [AW-1:0]     rd_a   [NUM_RD];
    logic [AW-1:0]     wr_a   [NUM_WR];
    logic [DATA_W-1:0] wr_d   [NUM_WR];
    logic [AW-1:0]     rsv_a  [NUM_RSV];
    logic [CNT_W-1:0]  sb_cnt [NUM_REGS];
    logic [INC_W-1:0]  sb_inc [NUM_REGS];
    logic [DEC_W-1:0]  sb_dec [NUM_REGS];
    logic [NUM_REGS-1:0] sb_full;
    logic [NUM_REGS-1:0] sb_uflow;

    always_comb begin
        for (int r = 0; r < NUM_RD; r++)  rd_a[r]  = rd_addr[r*AW +: AW];
        for (int p = 0; p < NUM_WR; p++)  wr_a[p]  = wr_addr[p*AW +: AW];
        for (int p = 0; p < NUM_WR; p++)  wr_d[p]  = wr_data[p*DATA_W +: DATA_W];
        for (int k = 0; k < NUM_RSV; k++) rsv_a[k] = rsv_addr[k*AW +: AW];
    end

    // Reservation ports are granted in index order; a retiring write this cycle
    // does not free a slot for a same-cycle reservation.
    always_comb begin : sb_decode
        logic [NUM_RSV-1:0] ok_v;
        logic [INC_W-1:0]   inc_v [NUM_REGS];
        logic [DEC_W-1:0]   dec_v [NUM_REGS];
        int                 prior;
        ok_v  = '1;
        prior = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_v[i] = '0;
            dec_v[i] = '0;
        end
        for (int p = 0; p < NUM_WR; p++)
            if (wr_en[p]) dec_v[wr_a[p]] = dec_v[wr_a[p]] + DEC_W'(1);
        for (int k = 0; k < NUM_RSV; k++) begin
            prior = 0;
            for (int j = 0; j < k; j++)
                if (rsv_en[j] && ok_v[j] && rsv_a[j] == rsv_a[k]) prior++;
            ok_v[k] = (prior == 0) ? !sb_full[rsv_a[k]]
                                   : (int'(sb_cnt[rsv_a[k]]) + prior != CNT_MAX);
            if (rsv_en[k] && ok_v[k]) inc_v[rsv_a[k]] = inc_v[rsv_a[k]] + INC_W'(1);
        end
        rsv_ok = ok_v;
        sb_inc = inc_v;
        sb_dec = dec_v;
    end

    // With bypass, a register being retired this cycle already reads as free.
    always_comb begin : rd_path
        logic [DATA_W-1:0] d;
        logic [AW-1:0]     a;
        int                w;
        d       = '0;
        a       = '0;
        w       = 0;
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            a = rd_a[r];
            d = regs[a];
            w = 0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_a[p] == a) begin
                    w++;
                    if (BYPASS != 0) d = wr_d[p];
                end
            end
            rd_data[r*DATA_W +: DATA_W] = d;
            rd_busy[r] = (BYPASS != 0) ? (int'(sb_cnt[a]) > w) : (sb_cnt[a] != '0);
        end
    end

    // Later ports override earlier ones on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++)
                if (wr_en[p]) regs[wr_a[p]] <= wr_d[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          sb_err <= 1'b0;
        else if (|sb_uflow) sb_err <= 1'b1;
    end

    assign sp_val = regs[SP_IDX];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
        tinker_sb_cnt #(
            .CNT_W (CNT_W),
            .INC_W (INC_W),
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (sb_inc[i]),
            .dec       (sb_dec[i]),
            .cnt       (sb_cnt[i]),
            .full      (sb_full[i]),
            .underflow (sb_uflow[i])
        );
    end

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Bench for tinker_regfile_sb: directed scenarios plus randomized traffic, run on a
// bypassing and a non-bypassing instance that share all inputs.
`timescale 1ns/1ps
module tb_tinker_regfile_sb;

    localparam int DW = 64, NR = 32, AW = 5, NRD = 3, NWR = 2, NRS = 1, CW = 2;
    localparam int CMAX = 3;
    localparam logic [63:0] SPV = 64'd524288;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data, rd_data_nb;
    logic [NRD-1:0]      rd_busy, rd_busy_nb;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*DW-1:0]   wr_data;
    logic [NRS-1:0]      rsv_en, rsv_ok, rsv_ok_nb;
    logic [NRS*AW-1:0]   rsv_addr;
    logic [DW-1:0]       sp_val, sp_val_nb;
    logic                sb_err, sb_err_nb;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: register contents, outstanding-write counts, sticky error.
    logic [63:0] m_regs [NR];
    int          m_cnt  [NR];
    bit          m_err;

    always #5 clk = ~clk;

    tinker_regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
        .NUM_RSV(NRS), .CNT_W(CW), .SP_IDX(31), .SP_RESET(SPV), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .sp_val(sp_val), .sb_err(sb_err));

    tinker_regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
        .NUM_RSV(NRS), .CNT_W(CW), .SP_IDX(31), .SP_RESET(SPV), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_nb), .sp_val(sp_val_nb), .sb_err(sb_err_nb));

    task automatic set_rd(input int r, input int a);
        rd_addr[r*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input bit en, input int a, input logic [63:0] d);
        wr_en[p]              = en;
        wr_addr[p*AW +: AW]   = AW'(a);
        wr_data[p*DW +: DW]   = d;
    endtask

    task automatic set_rsv(input bit en, input int a);
        rsv_en[0]        = en;
        rsv_addr[AW-1:0] = AW'(a);
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = '0;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = (i == 31) ? SPV : 64'd0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endfunction

    // A reservation is refused when the register already has the maximum number
    // of writes outstanding, counting grants to earlier ports this cycle.
    function automatic logic [NRS-1:0] exp_ok();
        logic [NRS-1:0] ok;
        int prior, a;
        ok = '1;
        for (int k = 0; k < NRS; k++) begin
            a = int'(rsv_addr[k*AW +: AW]);
            prior = 0;
            for (int j = 0; j < k; j++)
                if (rsv_en[j] && ok[j] && rsv_addr[j*AW +: AW] == rsv_addr[k*AW +: AW]) prior++;
            ok[k] = (m_cnt[a] + prior != CMAX);
        end
        return ok;
    endfunction

    function automatic int writes_to(input int a);
        int w = 0;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) w++;
        return w;
    endfunction

    function automatic logic [63:0] exp_rd(input int r, input bit byp);
        int a = int'(rd_addr[r*AW +: AW]);
        logic [63:0] d = m_regs[a];
        if (byp)
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) d = wr_data[p*DW +: DW];
        return d;
    endfunction

    function automatic logic exp_busy(input int r, input bit byp);
        int a = int'(rd_addr[r*AW +: AW]);
        return byp ? (m_cnt[a] - writes_to(a) > 0) : (m_cnt[a] > 0);
    endfunction

    // One clock: advance the reference model with the inputs currently applied.
    task automatic tick();
        logic [NRS-1:0] ok;
        int rr [NR];
        int ww [NR];
        logic [63:0] nregs [NR];
        int a;
        ok = exp_ok();
        for (int i = 0; i < NR; i++) begin
            rr[i] = 0; ww[i] = 0; nregs[i] = m_regs[i];
        end
        for (int k = 0; k < NRS; k++)
            if (rsv_en[k] && ok[k]) rr[int'(rsv_addr[k*AW +: AW])]++;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
                a = int'(wr_addr[p*AW +: AW]);
                ww[a]++;
                nregs[a] = wr_data[p*DW +: DW];
            end
        end
        @(posedge clk);
        for (int i = 0; i < NR; i++) begin
            if (m_cnt[i] + rr[i] < ww[i]) begin
                m_cnt[i] = 0;
                m_err    = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + rr[i] - ww[i];
            end
            m_regs[i] = nregs[i];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        set_rd(0, 31); set_rd(1, 5);
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1;
        n_cmp++; if (rd_data[63:0] !== SPV) begin n_bad++; $display("FAIL rst_rd0: got %0d want %0d", rd_data[63:0], SPV); end
        n_cmp++; if (rd_data[127:64] !== 64'd0) begin n_bad++; $display("FAIL rst_rd1: got %0d want 0", rd_data[127:64]); end
        n_cmp++; if (rd_busy !== 3'b000) begin n_bad++; $display("FAIL rst_busy: got %b want 000", rd_busy); end
        n_cmp++; if (sb_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", sb_err); end
        n_cmp++; if (sp_val !== SPV) begin n_bad++; $display("FAIL rst_sp: got %0d want %0d", sp_val, SPV); end
        n_cmp++; if (rsv_ok !== 1'b1) begin n_bad++; $display("FAIL rst_rsv_ok: got %b want 1", rsv_ok); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reserve_bypass();
        idle(); set_rd(0, 7); set_rsv(1, 7); #1;
        n_cmp++; if (rsv_ok !== 1'b1) begin n_bad++; $display("FAIL rsv7_ok: got %b want 1", rsv_ok); end
        n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL rsv7_busy_c1: got %b want 0", rd_busy[0]); end
        tick(); idle(); #1;
        n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL rsv7_busy_c2: got %b want 1", rd_busy[0]); end
        n_cmp++; if (rd_busy_nb[0] !== 1'b1) begin n_bad++; $display("FAIL rsv7_busy_nb_c2: got %b want 1", rd_busy_nb[0]); end
        tick(); tick();
        set_wr(0, 1, 7, 64'hDEAD); #1;
        n_cmp++; if (rd_data[63:0] !== 64'hDEAD) begin n_bad++; $display("FAIL byp7_data: got %h want dead", rd_data[63:0]); end
        n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL byp7_busy: got %b want 0", rd_busy[0]); end
        n_cmp++; if (rd_data_nb[63:0] !== 64'd0) begin n_bad++; $display("FAIL nb7_old: got %h want 0", rd_data_nb[63:0]); end
        n_cmp++; if (rd_busy_nb[0] !== 1'b1) begin n_bad++; $display("FAIL nb7_busy: got %b want 1", rd_busy_nb[0]); end
        tick(); idle(); #1;
        n_cmp++; if (rd_data[63:0] !== 64'hDEAD) begin n_bad++; $display("FAIL reg7: got %h want dead", rd_data[63:0]); end
        n_cmp++; if (rd_data_nb[63:0] !== 64'hDEAD) begin n_bad++; $display("FAIL reg7_nb: got %h want dead", rd_data_nb[63:0]); end
        n_cmp++; if (rd_busy_nb[0] !== 1'b0) begin n_bad++; $display("FAIL reg7_nb_busy: got %b want 0", rd_busy_nb[0]); end
    endtask

    task automatic test_dual_write();
        idle(); set_rd(0, 3);
        for (int i = 0; i < 2; i++) begin
            set_rsv(1, 3); #1;
            n_cmp++; if (rsv_ok !== 1'b1) begin n_bad++; $display("FAIL rsv3_ok%0d: got %b want 1", i, rsv_ok); end
            tick();
        end
        idle();
        set_wr(0, 1, 3, 64'h11); set_wr(1, 1, 3, 64'h22); #1;
        n_cmp++; if (rd_data[63:0] !== 64'h22) begin n_bad++; $display("FAIL dual_byp: got %h want 22", rd_data[63:0]); end
        n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL dual_busy: got %b want 0", rd_busy[0]); end
        tick(); idle(); #1;
        n_cmp++; if (rd_data_nb[63:0] !== 64'h22) begin n_bad++; $display("FAIL dual_reg: got %h want 22", rd_data_nb[63:0]); end
        n_cmp++; if (rd_busy_nb[0] !== 1'b0) begin n_bad++; $display("FAIL dual_cnt0: got %b want 0", rd_busy_nb[0]); end
        n_cmp++; if (sb_err !== 1'b0) begin n_bad++; $display("FAIL dual_err: got %b want 0", sb_err); end
    endtask

    task automatic test_saturate();
        idle(); set_rd(0, 9);
        for (int i = 0; i < 3; i++) begin
            set_rsv(1, 9); #1;
            n_cmp++; if (rsv_ok !== 1'b1) begin n_bad++; $display("FAIL sat_ok%0d: got %b want 1", i, rsv_ok); end
            tick();
        end
        set_rsv(1, 9); #1;
        n_cmp++; if (rsv_ok !== 1'b0) begin n_bad++; $display("FAIL sat_4th: got %b want 0", rsv_ok); end
        n_cmp++; if (rd_busy_nb[0] !== 1'b1) begin n_bad++; $display("FAIL sat_busy: got %b want 1", rd_busy_nb[0]); end
        tick();
        // Still full after the refused request; a retiring write does not free a slot.
        set_wr(0, 1, 9, 64'h91); #1;
        n_cmp++; if (rsv_ok !== 1'b0) begin n_bad++; $display("FAIL sat_retire_ok: got %b want 0", rsv_ok); end
        n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sat_retire_busy: got %b want 1", rd_busy[0]); end
        tick();
        set_wr(0, 1, 9, 64'h92); #1;
        n_cmp++; if (rsv_ok !== 1'b1) begin n_bad++; $display("FAIL swap_ok: got %b want 1", rsv_ok); end
        n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL swap_busy: got %b want 1", rd_busy[0]); end
        tick(); idle(); #1;
        n_cmp++; if (rd_busy_nb[0] !== 1'b1) begin n_bad++; $display("FAIL swap_hold: got %b want 1", rd_busy_nb[0]); end
        set_wr(0, 1, 9, 64'h93); set_wr(1, 1, 9, 64'h94); #1;
        n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL drain_busy: got %b want 0", rd_busy[0]); end
        tick(); idle(); #1;
        n_cmp++; if (rd_busy_nb[0] !== 1'b0) begin n_bad++; $display("FAIL drain_cnt0: got %b want 0", rd_busy_nb[0]); end
        n_cmp++; if (sb_err !== 1'b0) begin n_bad++; $display("FAIL drain_err: got %b want 0", sb_err); end
        n_cmp++; if (rd_data[63:0] !== 64'h94) begin n_bad++; $display("FAIL drain_data: got %h want 94", rd_data[63:0]); end
    endtask

    task automatic test_no_bypass();
        idle(); set_rd(0, 2); set_rsv(1, 2);
        tick(); idle();
        set_wr(0, 1, 2, 64'h77); #1;
        n_cmp++; if (rd_data_nb[63:0] !== 64'd0) begin n_bad++; $display("FAIL nb2_old: got %h want 0", rd_data_nb[63:0]); end
        n_cmp++; if (rd_data[63:0] !== 64'h77) begin n_bad++; $display("FAIL byp2_new: got %h want 77", rd_data[63:0]); end
        tick(); idle(); #1;
        n_cmp++; if (rd_data_nb[63:0] !== 64'h77) begin n_bad++; $display("FAIL nb2_new: got %h want 77", rd_data_nb[63:0]); end
    endtask

    task automatic test_unreserved_write();
        idle(); set_rd(0, 4);
        set_wr(0, 1, 4, 64'h5); #1;
        n_cmp++; if (sb_err !== 1'b0) begin n_bad++; $display("FAIL unrsv_err_same: got %b want 0", sb_err); end
        tick(); idle(); #1;
        n_cmp++; if (sb_err !== 1'b1) begin n_bad++; $display("FAIL unrsv_err: got %b want 1", sb_err); end
        n_cmp++; if (rd_data_nb[63:0] !== 64'h5) begin n_bad++; $display("FAIL unrsv_data: got %h want 5", rd_data_nb[63:0]); end
        tick(); tick(); #1;
        n_cmp++; if (sb_err !== 1'b1) begin n_bad++; $display("FAIL unrsv_sticky: got %b want 1", sb_err); end
        // Reservation lost across reset: its later writeback must flag an error.
        set_rsv(1, 10); tick();
        do_reset(); #1;
        n_cmp++; if (sb_err !== 1'b0) begin n_bad++; $display("FAIL rst_clear_err: got %b want 0", sb_err); end
        n_cmp++; if (rd_data[63:0] !== 64'd0) begin n_bad++; $display("FAIL rst_clear_r4: got %h want 0", rd_data[63:0]); end
        set_rd(1, 10); #1;
        n_cmp++; if (rd_busy_nb[1] !== 1'b0) begin n_bad++; $display("FAIL rst_clear_busy: got %b want 0", rd_busy_nb[1]); end
        set_wr(0, 1, 10, 64'hA); tick(); idle(); #1;
        n_cmp++; if (sb_err !== 1'b1) begin n_bad++; $display("FAIL stale_wb_err: got %b want 1", sb_err); end
        do_reset();
    endtask

    function automatic int pick();
        int a = int'($urandom_range(0, 8));
        return (a == 8) ? 31 : a;
    endfunction

    task automatic test_random();
        logic [NRS-1:0] eok;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) do_reset();
            for (int r = 0; r < NRD; r++) set_rd(r, pick());
            for (int p = 0; p < NWR; p++) set_wr(p, $urandom_range(0, 2) == 0, pick(), {$urandom, $urandom});
            set_rsv(1'($urandom_range(0, 1)), pick());
            #1;
            eok = exp_ok();
            for (int r = 0; r < NRD; r++) begin
                n_cmp++; if (rd_data[r*DW +: DW] !== exp_rd(r, 1)) begin n_bad++;
                    $display("FAIL rnd_rd%0d c%0d: got %h want %h", r, i, rd_data[r*DW +: DW], exp_rd(r, 1)); end
                n_cmp++; if (rd_data_nb[r*DW +: DW] !== exp_rd(r, 0)) begin n_bad++;
                    $display("FAIL rnd_rd_nb%0d c%0d: got %h want %h", r, i, rd_data_nb[r*DW +: DW], exp_rd(r, 0)); end
                n_cmp++; if (rd_busy[r] !== exp_busy(r, 1)) begin n_bad++;
                    $display("FAIL rnd_busy%0d c%0d: got %b want %b", r, i, rd_busy[r], exp_busy(r, 1)); end
                n_cmp++; if (rd_busy_nb[r] !== exp_busy(r, 0)) begin n_bad++;
                    $display("FAIL rnd_busy_nb%0d c%0d: got %b want %b", r, i, rd_busy_nb[r], exp_busy(r, 0)); end
            end
            n_cmp++; if (rsv_ok !== eok) begin n_bad++; $display("FAIL rnd_rsv_ok c%0d: got %b want %b", i, rsv_ok, eok); end
            n_cmp++; if (rsv_ok_nb !== eok) begin n_bad++; $display("FAIL rnd_rsv_ok_nb c%0d: got %b want %b", i, rsv_ok_nb, eok); end
            n_cmp++; if (sp_val !== m_regs[31]) begin n_bad++; $display("FAIL rnd_sp c%0d: got %h want %h", i, sp_val, m_regs[31]); end
            n_cmp++; if (sp_val_nb !== m_regs[31]) begin n_bad++; $display("FAIL rnd_sp_nb c%0d: got %h want %h", i, sp_val_nb, m_regs[31]); end
            n_cmp++; if (sb_err !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", i, sb_err, m_err); end
            n_cmp++; if (sb_err_nb !== m_err) begin n_bad++; $display("FAIL rnd_err_nb c%0d: got %b want %b", i, sb_err_nb, m_err); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_reserve_bypass();
        test_dual_write();
        test_saturate();
        test_no_bypass();
        test_unreserved_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
